id_ex_stage: RTL and testbench

//  ID/EX pipeline register directly upstream of the ALU. Captures decoded operands and control,

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands and control,
// resolves EX/MEM and MEM/WB forwarding, muxes ALU sources and flags load-use hazards.
module id_ex_stage #(
    parameter int SIZE     = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ID_VALID,
    input  logic [SIZE-1:0]     ID_PC,
    input  logic [SIZE-1:0]     ID_RS1_DATA,
    input  logic [SIZE-1:0]     ID_RS2_DATA,
    input  logic [SIZE-1:0]     ID_IMM,
    input  logic [REG_ADDR-1:0] ID_RS1,
    input  logic [REG_ADDR-1:0] ID_RS2,
    input  logic [REG_ADDR-1:0] ID_RD,
    input  logic [3:0]          ID_OPERATION,
    input  logic                ID_SRC_A_PC,
    input  logic                ID_SRC_B_IMM,
    input  logic                ID_REG_WRITE,
    input  logic                ID_MEM_READ,
    input  logic                ID_MEM_WRITE,
    input  logic                ID_BRANCH,
    input  logic                STALL,
    input  logic                FLUSH,
    input  logic [REG_ADDR-1:0] EXMEM_RD,
    input  logic [REG_ADDR-1:0] MEMWB_RD,
    input  logic                EXMEM_REG_WRITE,
    input  logic                MEMWB_REG_WRITE,
    input  logic [SIZE-1:0]     EXMEM_RESULT,
    input  logic [SIZE-1:0]     MEMWB_RESULT,
    output logic [SIZE-1:0]     A,
    output logic [SIZE-1:0]     B,
    output logic [3:0]          OPERATION,
    output logic [SIZE-1:0]     STORE_DATA,
    output logic [SIZE-1:0]     EX_PC,
    output logic [REG_ADDR-1:0] EX_RD,
    output logic                EX_VALID,
    output logic                EX_REG_WRITE,
    output logic                EX_MEM_READ,
    output logic                EX_MEM_WRITE,
    output logic                EX_BRANCH,
    output logic                LOAD_USE_HAZARD
);

    // control state
    logic                ex_valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [3:0]          operation;

    // payload state
    logic [SIZE-1:0]     pc;
    logic [SIZE-1:0]     imm;
    logic [SIZE-1:0]     rs1_data;
    logic [SIZE-1:0]     rs2_data;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;
    logic                src_a_pc;
    logic                src_b_imm;

    logic [SIZE-1:0]     fwd_rs1;
    logic [SIZE-1:0]     fwd_rs2;

    // EX/MEM is the younger producer, so it takes priority over MEM/WB.
    always_comb begin
        fwd_rs1 = rs1_data;
        if (EXMEM_REG_WRITE && (EXMEM_RD == rs1) && (rs1 != '0))
            fwd_rs1 = EXMEM_RESULT;
        else if (MEMWB_REG_WRITE && (MEMWB_RD == rs1) && (rs1 != '0))
            fwd_rs1 = MEMWB_RESULT;
    end

    always_comb begin
        fwd_rs2 = rs2_data;
        if (EXMEM_REG_WRITE && (EXMEM_RD == rs2) && (rs2 != '0))
            fwd_rs2 = EXMEM_RESULT;
        else if (MEMWB_REG_WRITE && (MEMWB_RD == rs2) && (rs2 != '0))
            fwd_rs2 = MEMWB_RESULT;
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            ex_valid  <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            branch    <= 1'b0;
            operation <= '0;
        end else if (!STALL) begin
            ex_valid  <= ID_VALID;
            reg_write <= ID_REG_WRITE;
            mem_read  <= ID_MEM_READ;
            mem_write <= ID_MEM_WRITE;
            branch    <= ID_BRANCH;
            operation <= ID_OPERATION;
        end
    end

    // A flushed slot's payload is don't-care, so flush simply loads like a normal edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc        <= '0;
            imm       <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            src_a_pc  <= 1'b0;
            src_b_imm <= 1'b0;
        end else if (STALL && !FLUSH) begin
            // capture forwarded operands so a producer retiring mid-stall is kept
            rs1_data  <= fwd_rs1;
            rs2_data  <= fwd_rs2;
        end else begin
            pc        <= ID_PC;
            imm       <= ID_IMM;
            rs1_data  <= ID_RS1_DATA;
            rs2_data  <= ID_RS2_DATA;
            rs1       <= ID_RS1;
            rs2       <= ID_RS2;
            rd        <= ID_RD;
            src_a_pc  <= ID_SRC_A_PC;
            src_b_imm <= ID_SRC_B_IMM;
        end
    end

    assign A            = src_a_pc  ? pc  : fwd_rs1;
    assign B            = src_b_imm ? imm : fwd_rs2;
    assign STORE_DATA   = fwd_rs2;
    assign OPERATION    = operation;
    assign EX_PC        = pc;
    assign EX_RD        = rd;
    assign EX_VALID     = ex_valid;
    assign EX_REG_WRITE = reg_write;
    assign EX_MEM_READ  = mem_read;
    assign EX_MEM_WRITE = mem_write;
    assign EX_BRANCH    = branch;

    assign LOAD_USE_HAZARD = ex_valid && mem_read && (rd != '0) && ID_VALID &&
                             ((rd == ID_RS1) || (rd == ID_RS2));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for loads/forwarding/hazards/flush,
// plus hand-written reset and stall sequences.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ID_VALID;
    logic [31:0] ID_PC, ID_RS1_DATA, ID_RS2_DATA, ID_IMM;
    logic [4:0]  ID_RS1, ID_RS2, ID_RD;
    logic [3:0]  ID_OPERATION;
    logic        ID_SRC_A_PC, ID_SRC_B_IMM;
    logic        ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE, ID_BRANCH;
    logic        STALL, FLUSH;
    logic [4:0]  EXMEM_RD, MEMWB_RD;
    logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
    logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
    logic [31:0] A, B, STORE_DATA, EX_PC;
    logic [3:0]  OPERATION;
    logic [4:0]  EX_RD;
    logic        EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_BRANCH;
    logic        LOAD_USE_HAZARD;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    id_ex_stage #(.SIZE(32), .REG_ADDR(5)) dut (
        .CLK(CLK), .RST(RST), .ID_VALID(ID_VALID), .ID_PC(ID_PC),
        .ID_RS1_DATA(ID_RS1_DATA), .ID_RS2_DATA(ID_RS2_DATA), .ID_IMM(ID_IMM),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD), .ID_OPERATION(ID_OPERATION),
        .ID_SRC_A_PC(ID_SRC_A_PC), .ID_SRC_B_IMM(ID_SRC_B_IMM),
        .ID_REG_WRITE(ID_REG_WRITE), .ID_MEM_READ(ID_MEM_READ),
        .ID_MEM_WRITE(ID_MEM_WRITE), .ID_BRANCH(ID_BRANCH),
        .STALL(STALL), .FLUSH(FLUSH),
        .EXMEM_RD(EXMEM_RD), .MEMWB_RD(MEMWB_RD),
        .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .MEMWB_REG_WRITE(MEMWB_REG_WRITE),
        .EXMEM_RESULT(EXMEM_RESULT), .MEMWB_RESULT(MEMWB_RESULT),
        .A(A), .B(B), .OPERATION(OPERATION), .STORE_DATA(STORE_DATA),
        .EX_PC(EX_PC), .EX_RD(EX_RD), .EX_VALID(EX_VALID),
        .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_READ(EX_MEM_READ),
        .EX_MEM_WRITE(EX_MEM_WRITE), .EX_BRANCH(EX_BRANCH),
        .LOAD_USE_HAZARD(LOAD_USE_HAZARD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        // stimulus
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        sa, sb, rw, mr, mw, br;
        logic        stall, flush;
        logic        exm_rw;
        logic [4:0]  exm_rd;
        logic [31:0] exm_res;
        logic        mwb_rw;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_res;
        // expected after the edge
        logic        chk_data;
        logic [31:0] e_a, e_b, e_sd;
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic        e_valid, e_rw, e_mr, e_luh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t blank();
        vec_t v;
        v = '{valid: 1'b1, pc: 32'h0, rs1d: 32'h0, rs2d: 32'h0, imm: 32'h0,
              rs1: 5'd0, rs2: 5'd0, rd: 5'd0, op: 4'd0,
              sa: 1'b0, sb: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0,
              stall: 1'b0, flush: 1'b0,
              exm_rw: 1'b0, exm_rd: 5'd0, exm_res: 32'h0,
              mwb_rw: 1'b0, mwb_rd: 5'd0, mwb_res: 32'h0,
              chk_data: 1'b1, e_a: 32'h0, e_b: 32'h0, e_sd: 32'h0,
              e_op: 4'd0, e_rd: 5'd0, e_valid: 1'b1, e_rw: 1'b0, e_mr: 1'b0, e_luh: 1'b0};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ID_VALID = v.valid; ID_PC = v.pc; ID_RS1_DATA = v.rs1d; ID_RS2_DATA = v.rs2d;
        ID_IMM = v.imm; ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_RD = v.rd; ID_OPERATION = v.op;
        ID_SRC_A_PC = v.sa; ID_SRC_B_IMM = v.sb; ID_REG_WRITE = v.rw; ID_MEM_READ = v.mr;
        ID_MEM_WRITE = v.mw; ID_BRANCH = v.br; STALL = v.stall; FLUSH = v.flush;
        EXMEM_REG_WRITE = v.exm_rw; EXMEM_RD = v.exm_rd; EXMEM_RESULT = v.exm_res;
        MEMWB_REG_WRITE = v.mwb_rw; MEMWB_RD = v.mwb_rd; MEMWB_RESULT = v.mwb_res;
    endtask

    initial begin
        vec_t v;

        // ---- reset with random decode inputs ----
        drive(blank());
        RST = 1'b1;
        ID_VALID = 1'b1; ID_PC = $urandom; ID_RS1_DATA = $urandom; ID_RS2_DATA = $urandom;
        ID_IMM = $urandom; ID_RS1 = 5'($urandom); ID_RS2 = 5'($urandom); ID_RD = 5'($urandom);
        ID_OPERATION = 4'($urandom); ID_SRC_A_PC = 1'b1; ID_SRC_B_IMM = 1'b1;
        ID_REG_WRITE = 1'b1; ID_MEM_READ = 1'b1; ID_MEM_WRITE = 1'b1; ID_BRANCH = 1'b1;
        @(posedge CLK); #1;
        chk("rst_valid", 32'(EX_VALID), 32'd0);
        chk("rst_op",    32'(OPERATION), 32'd0);
        chk("rst_a",     A, 32'd0);
        chk("rst_b",     B, 32'd0);
        chk("rst_flags", {28'd0, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE, EX_BRANCH}, 32'd0);
        chk("rst_pc",    EX_PC, 32'd0);
        chk("rst_luh",   32'(LOAD_USE_HAZARD), 32'd0);
        RST = 1'b0;

        // ---- vector table ----
        // 0: both later stages write x3, EX/MEM wins
        v = blank(); v.rs1 = 5'd3; v.rs1d = 32'd5; v.rs2 = 5'd4; v.rs2d = 32'd7; v.op = 4'd2;
        v.rd = 5'd6; v.rw = 1'b1; v.exm_rw = 1'b1; v.exm_rd = 5'd3; v.exm_res = 32'd100;
        v.mwb_rw = 1'b1; v.mwb_rd = 5'd3; v.mwb_res = 32'd200;
        v.e_a = 32'd100; v.e_b = 32'd7; v.e_sd = 32'd7; v.e_op = 4'd2; v.e_rd = 5'd6; v.e_rw = 1'b1;
        tbl.push_back(v);
        // 1: EX/MEM stops writing, MEM/WB forwards
        v.exm_rw = 1'b0; v.e_a = 32'd200; tbl.push_back(v);
        // 2: x0 sources are never forwarded
        v = blank(); v.rs1d = 32'd9; v.rs2d = 32'd11; v.op = 4'd1; v.rd = 5'd1;
        v.exm_rw = 1'b1; v.exm_res = 32'd100; v.mwb_rw = 1'b1; v.mwb_res = 32'd200;
        v.e_a = 32'd9; v.e_b = 32'd11; v.e_sd = 32'd11; v.e_op = 4'd1; v.e_rd = 5'd1;
        tbl.push_back(v);
        // 3: PC/IMM sources; store data still forwarded
        v = blank(); v.sa = 1'b1; v.sb = 1'b1; v.pc = 32'h40; v.imm = 32'h12345;
        v.rs1 = 5'd3; v.rs1d = 32'd5; v.rs2 = 5'd4; v.rs2d = 32'd7; v.op = 4'd4; v.rd = 5'd2;
        v.mw = 1'b1; v.exm_rw = 1'b1; v.exm_rd = 5'd4; v.exm_res = 32'h55;
        v.e_a = 32'h40; v.e_b = 32'h12345; v.e_sd = 32'h55; v.e_op = 4'd4; v.e_rd = 5'd2;
        tbl.push_back(v);
        // 4: lw x5 in EX, decode reads x5 on rs2 -> hazard
        v = blank(); v.rd = 5'd5; v.mr = 1'b1; v.rw = 1'b1; v.rs1 = 5'd1; v.rs1d = 32'h10;
        v.rs2 = 5'd5; v.rs2d = 32'h20; v.op = 4'd2; v.sb = 1'b1; v.imm = 32'd8;
        v.e_a = 32'h10; v.e_b = 32'd8; v.e_sd = 32'h20; v.e_op = 4'd2; v.e_rd = 5'd5;
        v.e_rw = 1'b1; v.e_mr = 1'b1; v.e_luh = 1'b1;
        tbl.push_back(v);
        // 5: load into x0 is never a hazard
        v.rd = 5'd0; v.rs2 = 5'd0; v.e_rd = 5'd0; v.e_luh = 1'b0; tbl.push_back(v);
        // 6: non-load writing x5, decode reads x5 on rs1 -> no hazard
        v = blank(); v.rd = 5'd5; v.rw = 1'b1; v.rs1 = 5'd5; v.rs1d = 32'h33;
        v.e_a = 32'h33; v.e_rd = 5'd5; v.e_rw = 1'b1; tbl.push_back(v);
        // 7: load x5, rs1 match -> hazard
        v.mr = 1'b1; v.e_mr = 1'b1; v.e_luh = 1'b1; tbl.push_back(v);
        // 8: same but decode slot not valid
        v.valid = 1'b0; v.e_valid = 1'b0; v.e_luh = 1'b0; tbl.push_back(v);
        // 9: flush inserts a bubble
        v = blank(); v.rd = 5'd7; v.rw = 1'b1; v.mr = 1'b1; v.mw = 1'b1; v.br = 1'b1; v.op = 4'd7;
        v.flush = 1'b1; v.chk_data = 1'b0; v.e_valid = 1'b0; v.e_op = 4'd0; tbl.push_back(v);
        // 10: stall and flush together -> flush wins
        v.stall = 1'b1; tbl.push_back(v);
        // 11: normal load resumes
        v = blank(); v.rs1 = 5'd7; v.rs1d = 32'h77; v.rs2 = 5'd8; v.rs2d = 32'h88; v.op = 4'd3;
        v.rd = 5'd9; v.rw = 1'b1;
        v.e_a = 32'h77; v.e_b = 32'h88; v.e_sd = 32'h88; v.e_op = 4'd3; v.e_rd = 5'd9; v.e_rw = 1'b1;
        tbl.push_back(v);

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge CLK); #1;
            chk($sformatf("v%0d_valid", i), 32'(EX_VALID),        32'(tbl[i].e_valid));
            chk($sformatf("v%0d_op", i),    32'(OPERATION),       32'(tbl[i].e_op));
            chk($sformatf("v%0d_rw", i),    32'(EX_REG_WRITE),    32'(tbl[i].e_rw));
            chk($sformatf("v%0d_mr", i),    32'(EX_MEM_READ),     32'(tbl[i].e_mr));
            chk($sformatf("v%0d_luh", i),   32'(LOAD_USE_HAZARD), 32'(tbl[i].e_luh));
            if (tbl[i].chk_data) begin
                chk($sformatf("v%0d_a", i),  A,            tbl[i].e_a);
                chk($sformatf("v%0d_b", i),  B,            tbl[i].e_b);
                chk($sformatf("v%0d_sd", i), STORE_DATA,   tbl[i].e_sd);
                chk($sformatf("v%0d_rd", i), 32'(EX_RD),   32'(tbl[i].e_rd));
            end else begin
                chk($sformatf("v%0d_mw", i), 32'(EX_MEM_WRITE), 32'd0);
                chk($sformatf("v%0d_br", i), 32'(EX_BRANCH),    32'd0);
            end
        end

        // ---- stall while MEM/WB retires the rs1 producer ----
        v = blank(); v.rs1 = 5'd10; v.rs1d = 32'd1; v.rs2 = 5'd11; v.rs2d = 32'd2;
        v.op = 4'd5; v.rd = 5'd12; v.rw = 1'b1; v.pc = 32'h100;
        drive(v);
        @(posedge CLK); #1;
        chk("stl_load_a", A, 32'd1);
        STALL = 1'b1;
        ID_RS1 = 5'd14; ID_RS1_DATA = 32'h999; ID_RS2_DATA = 32'h777; ID_OPERATION = 4'd9;
        ID_RD = 5'd13; ID_PC = 32'h200; ID_VALID = 1'b0; ID_REG_WRITE = 1'b0;
        MEMWB_REG_WRITE = 1'b1; MEMWB_RD = 5'd10; MEMWB_RESULT = 32'hAB;
        #1;
        chk("stl_fwd_a", A, 32'hAB);
        @(posedge CLK); #1;
        MEMWB_REG_WRITE = 1'b0;
        #1;
        chk("stl1_a",  A, 32'hAB);
        chk("stl1_op", 32'(OPERATION), 32'd5);
        chk("stl1_rd", 32'(EX_RD), 32'd12);
        chk("stl1_pc", EX_PC, 32'h100);
        chk("stl1_valid", 32'(EX_VALID), 32'd1);
        @(posedge CLK); #1;
        chk("stl2_a",  A, 32'hAB);
        chk("stl2_b",  B, 32'd2);
        chk("stl2_op", 32'(OPERATION), 32'd5);
        chk("stl2_rw", 32'(EX_REG_WRITE), 32'd1);
        chk("stl2_pc", EX_PC, 32'h100);
        STALL = 1'b0;
        @(posedge CLK); #1;
        chk("stl_rel_a",     A, 32'h999);
        chk("stl_rel_op",    32'(OPERATION), 32'd9);
        chk("stl_rel_valid", 32'(EX_VALID), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
